fifo_sync_flags: RTL

//  Parametrised single-clock synchronous FIFO; next generation of the team's basic FIFO.

---
 rtl/fifo_sync_flags_if.sv | 34 +++
 rtl/fifo_sync_flags.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_sync_flags_if.sv
// Producer/consumer bundle for fifo_sync_flags: write/read requests, read data and status flags.
// The FIFO takes the slave modport; the driving agent takes the master modport.
interface fifo_sync_flags_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 16
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] datain;
    logic                  wr_en;
    logic                  rd_en;
    logic                  clr_err;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [LVL_W-1:0]      level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output datain, wr_en, rd_en, clr_err,
        input  dataout, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  datain, wr_en, rd_en, clr_err,
        output dataout, rd_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO of any depth with level, almost/full/empty flags and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads have one cycle latency.
module fifo_sync_flags #(
    parameter int DEPTH         = 8,
    parameter int DATA_WIDTH    = 16,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input logic              clk,
    input logic              resetn,
    fifo_sync_flags_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(DEPTH - 1);
    localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_AFULL  = LVL_W'(AFULL_THRESH);
    localparam logic [LVL_W-1:0] LVL_AEMPTY = LVL_W'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic                  overflow_q;
    logic                  underflow_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ovf_set;
    logic                  unf_set;

    // Explicit wrap keeps pointers legal when DEPTH is not a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full    = (level_q == LVL_MAX);
    assign empty   = (level_q == '0);
    assign rd_acc  = bus.rd_en & ~empty;
    assign wr_acc  = bus.wr_en & (~full | rd_acc);
    assign ovf_set = bus.wr_en & full & ~rd_acc;
    assign unf_set = bus.rd_en & empty;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.datain;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // A set event in the same cycle as clr_err keeps the flag high.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set)          overflow_q  <= 1'b1;
            else if (bus.clr_err) overflow_q  <= 1'b0;
            if (unf_set)          underflow_q <= 1'b1;
            else if (bus.clr_err) underflow_q <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.dataout  = empty ? '0 : mem[rd_ptr];
    assign bus.rd_valid = ~empty;
`else
    logic [DATA_WIDTH-1:0] dataout_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dataout_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) dataout_q <= mem[rd_ptr];
        end
    end

    assign bus.dataout  = dataout_q;
    assign bus.rd_valid = rd_valid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level_q >= LVL_AFULL);
    assign bus.almost_empty = (level_q <= LVL_AEMPTY);
    assign bus.level        = level_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule
